// File: rtl/my_ram_512_dma_pkg.sv
// my_ram_512_dma_pkg: shared types and defaults
// for the 512-word RAM block-transfer engine.
package my_ram_512_dma_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 10;
  localparam int MAX_LEN    = 512;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/my_ram_512_dma_ptr.sv
// my_dma_ptr: wrap-around address pointer.
// Ports: clk, rst_n (sync, low), ld/ld_val, inc, ptr.
module my_dma_ptr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (ld)
      ptr_d = ld_val;
    else if (inc)
      ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/my_ram_512_dma.sv
// my_ram_512_dma: copy/fill DMA in front of a
// 512-word RAM with a host pass-through port.
// Ports: clk, rst_n (sync, low); start, mode,
// src, dst, len, fill_val; busy, done; host_*
// pass-through; ram_addr/ram_in/ram_load to RAM,
// ram_out from RAM.
// Option MY_RAM_512_DMA_CHECKSUM_EN adds
// checksum: sum of written words since start.
import my_ram_512_dma_pkg::*;

module my_ram_512_dma #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_in,
  input  logic              host_load,
  output logic [DATA_W-1:0] host_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
`ifdef MY_RAM_512_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  len_clamp;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [DATA_W-1:0] wdata;
  logic              accept;

  assign len_clamp =
    (len > LEN_W'(MAX_LEN)) ?
    LEN_W'(MAX_LEN) : len;

  assign accept = (state_q == IDLE) && start;

  my_dma_ptr #(.W(ADDR_W)) u_src_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (accept),
    .inc    (state_q == READ),
    .ld_val (src),
    .ptr    (src_ptr)
  );

  my_dma_ptr #(.W(ADDR_W)) u_dst_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (accept),
    .inc    (state_q == WRITE),
    .ld_val (dst),
    .ptr    (dst_ptr)
  );

  assign wdata =
    (mode_q == MODE_FILL) ? fill_q : data_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          fill_d = fill_val;
          rem_d  = len_clamp;
          if (len_clamp == '0)
            state_d = DONE;
          else if (mode == MODE_COPY)
            state_d = READ;
          else
            state_d = WRITE;
        end
      end
      READ: begin
        data_d  = ram_out;
        state_d = WRITE;
      end
      WRITE: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1))
          state_d = DONE;
        else if (mode_q == MODE_COPY)
          state_d = READ;
        else
          state_d = WRITE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == READ) ||
             (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  // Host owns the RAM except in READ/WRITE.
  always_comb begin
    ram_addr = host_addr;
    ram_in   = host_in;
    ram_load = host_load;
    unique case (state_q)
      READ: begin
        ram_addr = src_ptr;
        ram_load = 1'b0;
      end
      WRITE: begin
        ram_addr = dst_ptr;
        ram_in   = wdata;
        ram_load = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign host_out = ram_out;

`ifdef MY_RAM_512_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept)
      csum_d = '0;
    else if (state_q == WRITE)
      csum_d = csum_q + wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      csum_q <= '0;
    else
      csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_my_ram_512_dma.sv
// tb_my_ram_512_dma: directed plus random
// transfers against an array reference model.
module tb_my_ram_512_dma;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [8:0]  src;
  logic [8:0]  dst;
  logic [9:0]  len;
  logic [15:0] fill_val;
  logic        busy;
  logic        done;
  logic [8:0]  host_addr;
  logic [15:0] host_in;
  logic        host_load;
  logic [15:0] host_out;
  logic [8:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;
`ifdef MY_RAM_512_DMA_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  my_ram_512_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill_val  (fill_val),
    .busy      (busy),
    .done      (done),
    .host_addr (host_addr),
    .host_in   (host_in),
    .host_load (host_load),
    .host_out  (host_out),
    .ram_addr  (ram_addr),
    .ram_in    (ram_in),
    .ram_load  (ram_load),
    .ram_out   (ram_out)
`ifdef MY_RAM_512_DMA_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // The RAM itself: sync write, comb read.
  logic [15:0] mem [512];
  always @(posedge clk)
    if (ram_load) mem[ram_addr] <= ram_in;
  assign ram_out = mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] r [512];
  int n_vec;
  int n_bad;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic host_wr(input int a,
                         input logic [15:0] v);
    @(negedge clk);
    host_addr = a[8:0];
    host_in   = v;
    host_load = 1'b1;
    @(negedge clk);
    host_load = 1'b0;
    r[a] = v;
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    host_load = 1'b0;
    for (int a = 0; a < 512; a++) begin
      host_addr = a[8:0];
      #1;
      if (host_out !== r[a]) bad++;
    end
    chk(tag, bad, 0);
    @(negedge clk);
  endtask

  // Reference: ascending word-by-word semantics.
  task automatic ref_xfer(input bit m,
                          input int s,
                          input int d,
                          input int l,
                          input logic [15:0] f);
    int n;
    n = (l > 512) ? 512 : l;
    for (int i = 0; i < n; i++) begin
      if (m)
        r[(d + i) % 512] = f;
      else
        r[(d + i) % 512] = r[(s + i) % 512];
    end
  endtask

  task automatic xfer(input bit m,
                      input int s,
                      input int d,
                      input int l,
                      input logic [15:0] f,
                      input bit hold,
                      input bit noise,
                      output int dc,
                      output int bc,
                      output int wc);
    @(negedge clk);
    mode     = m;
    src      = s[8:0];
    dst      = d[8:0];
    len      = l[9:0];
    fill_val = f;
    start    = 1'b1;
    @(posedge clk);
    dc = -1;
    bc = 0;
    wc = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (hold) begin
        src = 9'd300;
        len = 10'd7;
      end
      if (noise && busy) begin
        host_addr = 9'd300;
        host_in   = 16'hDEAD;
        host_load = 1'b1;
      end
      if (busy) bc++;
      if (busy && ram_load) wc++;
      if (done) begin
        dc = k;
        start = 1'b0;
        host_load = 1'b0;
        break;
      end
    end
    start = 1'b0;
    host_load = 1'b0;
    @(negedge clk);
    ref_xfer(m, s, d, l, f);
  endtask

  int dc, bc, wc;
  int rm, rs, rd, rl, nn;
  logic [15:0] rf;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    fill_val = '0;
    host_addr = '0;
    host_in = '0;
    host_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;

    for (int a = 0; a < 512; a++)
      host_wr(a, 16'($urandom));
    cmp_mem("preload");

    xfer(1, 0, 8, 4, 16'hBEEF, 0, 0, dc, bc, wc);
    chk("fill_done", dc, 5);
    chk("fill_busy", bc, 4);
    chk("fill_wr", wc, 4);
    cmp_mem("fill_mem");

    for (int a = 0; a < 4; a++)
      host_wr(a, 16'(a + 1));
    xfer(0, 0, 100, 4, 16'h0, 1, 1, dc, bc, wc);
    chk("copy_done", dc, 9);
    chk("copy_busy", bc, 8);
    chk("copy_wr", wc, 4);
    cmp_mem("copy_mem");

    xfer(1, 0, 510, 4, 16'd7, 0, 0, dc, bc, wc);
    chk("wrap_done", dc, 5);
    cmp_mem("wrap_mem");

    host_wr(0, 16'd5);
    xfer(0, 0, 1, 3, 16'h0, 0, 0, dc, bc, wc);
    cmp_mem("ovl_mem");
    host_addr = 9'd3;
    #1;
    chk("ovl_w3", int'(host_out), 5);

    xfer(1, 0, 20, 0, 16'h1234, 0, 0, dc, bc, wc);
    chk("len0_done", dc, 1);
    chk("len0_busy", bc, 0);
    chk("len0_wr", wc, 0);
    cmp_mem("len0_mem");

    rf = 16'($urandom);
    xfer(1, 0, 77, 600, rf, 0, 0, dc, bc, wc);
    chk("clamp_wr", wc, 512);
    chk("clamp_done", dc, 513);
    cmp_mem("clamp_mem");

    host_wr(42, 16'd9);
    host_addr = 9'd42;
    #1;
    chk("host_rd42", int'(host_out), 9);

    for (int t = 0; t < 6; t++) begin
      rm = int'($urandom_range(0, 1));
      rs = int'($urandom_range(0, 511));
      rd = int'($urandom_range(0, 511));
      rl = int'($urandom_range(0, 40));
      rf = 16'($urandom);
      xfer(rm[0], rs, rd, rl, rf, 0, 0,
           dc, bc, wc);
      nn = (rm == 1) ? rl + 1 : 2 * rl + 1;
      chk("rnd_done", dc, nn);
      chk("rnd_wr", wc, rl);
      cmp_mem("rnd_mem");
    end

    @(negedge clk);
    mode  = 1'b0;
    src   = 9'd200;
    dst   = 9'd250;
    len   = 10'd10;
    start = 1'b1;
    @(posedge clk);
    wc = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && ram_load) wc++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    rst_n = 1'b1;
    chk("abort_wr", wc, 2);
    bc = 0;
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_load) bc++;
      if (done) dc++;
    end
    chk("abort_nowr", bc, 0);
    chk("abort_nodone", dc, 0);
    ref_xfer(0, 200, 250, 2, 16'h0);
    cmp_mem("abort_mem");

`ifdef MY_RAM_512_DMA_CHECKSUM_EN
    xfer(1, 0, 400, 3, 16'h8000, 0, 0,
         dc, bc, wc);
    chk("csum", int'(checksum), 32768);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/my_ram_512_dma.md
Name: my_ram_512_dma

Overview:
Block-transfer engine placed directly upstream of the 512-word RAM (my_ram_512). It drives that RAM's addr/in/load inputs and samples its combinational out.
- When idle, it passes a host port straight through to the RAM.
- When started, it performs a word-by-word copy (RAM to RAM) or a constant fill over a contiguous address range, then pulses done.

Parameters:
ADDR_W, 9, RAM address width (512 words)
DATA_W, 16, RAM word width
LEN_W, 10, transfer length width (0..512 words)

Ports:
clk  input  1  rising-edge clock, shared with the RAM
rst_n  input  1  synchronous, active-low reset
start  input  1  request transfer; sampled only in IDLE
mode  input  1  0 = copy, 1 = fill
src  input  ADDR_W  copy source start address
dst  input  ADDR_W  destination start address
len  input  LEN_W  word count; values above 512 are clamped to 512
fill_val  input  DATA_W  fill word
busy  output  1  engine owns the RAM
done  output  1  one-cycle completion pulse
host_addr  input  ADDR_W  host address, used when not busy
host_in  input  DATA_W  host write data
host_load  input  1  host write enable
host_out  output  DATA_W  always equals ram_out
ram_addr  output  ADDR_W  to RAM addr
ram_in  output  DATA_W  to RAM in
ram_load  output  1  to RAM load
ram_out  input  DATA_W  from RAM out (combinational read)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- On reset (posedge clk with rst_n=0):
  - state goes to IDLE, busy=0, done=0
  - internal pointers, remaining count and data_reg are cleared
  - ram_load follows host_load, so no engine write occurs
  - reset mid-transfer aborts immediately; words already written stay written and no done pulse is issued
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - ram_addr=host_addr, ram_in=host_in, ram_load=host_load
  - if start=1 at the edge: latch src_ptr, dst_ptr, rem=min(len,512), mode, fill_val
  - if rem=0, go to DONE; else go to READ (copy) or WRITE (fill)
- READ (copy only):
  - ram_addr=src_ptr, ram_load=0
  - at the edge: data_reg<=ram_out, src_ptr<=src_ptr+1 (mod 512), go to WRITE
- WRITE:
  - ram_addr=dst_ptr, ram_load=1
  - ram_in = data_reg (copy) or fill_val (fill)
  - at the edge: dst_ptr<=dst_ptr+1 (mod 512), rem<=rem-1
  - if rem=1, go to DONE; else go to READ (copy) or stay in WRITE (fill)
- DONE:
  - done=1 for exactly one cycle; RAM muxed back to the host as in IDLE
  - next state is IDLE; start is ignored in DONE
- busy=1 exactly in READ and WRITE. host_load is ignored while busy.
- start while busy is ignored and is not queued.
- Latency, measured from the start-accept edge:
  - copy of N words: done is high in cycle 2N+1
  - fill of N words: done is high in cycle N+1
  - len=0: done is high in cycle 1 and no write occurs
- Address arithmetic wraps modulo 512; e.g. dst=510 with len=4 writes 510, 511, 0, 1.
- Overlapping copy runs in ascending order, one word at a time. If dst > src and the regions overlap, the source is overwritten before it is read; this is the defined behaviour (a replicating pattern).
- len=512 covers the full RAM; the final pointers equal the start pointers.

Optional Feature:
MY_RAM_512_DMA_CHECKSUM_EN
- Defined: adds output checksum[DATA_W-1:0]. It is cleared when start is accepted and adds each written word at the WRITE edge (sum mod 2^16). It holds its value after done until the next accepted start, and is cleared on reset.
- Undefined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package my_ram_512_dma_pkg holds:
  - state enum (IDLE, READ, WRITE, DONE)
  - mode constants MODE_COPY=0, MODE_FILL=1
  - ADDR_W, DATA_W, LEN_W defaults and MAX_LEN=512
- Sub-module my_dma_ptr is a wrap-around address pointer with synchronous load and increment, instantiated twice (src_ptr, dst_ptr).
- FSM, remaining counter and host mux stay in the top module.

Test Plan:
- Fill: fill mode, dst=8, len=4, fill_val=16'hBEEF → addresses 8..11 read BEEF, address 12 is unchanged; done is high in cycle 5; busy is high for exactly 4 cycles.
- Copy: preload 0..3 = 1,2,3,4; copy src=0, dst=100, len=4 → addresses 100..103 read 1,2,3,4; done is high in cycle 9; the source is unchanged.
- Wrap and overlap:
  - fill dst=510, len=4, fill_val=7 → 510, 511, 0, 1 equal 7
  - copy src=0, dst=1, len=3 with 0=5 → 0..3 all equal 5
- len=0 and clamping: start with len=0 → done in cycle 1, no ram_load while busy; len=600 → exactly 512 writes.
- Arbitration: start during busy is ignored. host_load=1 during busy causes no host write. After done, a host write to 42 with value 9 reads back 9 via host_out.
- Reset and checksum: rst_n=0 in the middle of a copy → next cycle busy=0 and done=0, no further writes, state IDLE. With MY_RAM_512_DMA_CHECKSUM_EN defined, a fill of 3 words of 16'h8000 gives checksum=16'h8000.
